// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline stage registers.
package mips_pipe_pkg;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register that clears on reset.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register: a head entry plus one skid entry, with flush and writeback mux.
//
//  state     | meaning
//  OCC_EMPTY | no entry held, out_valid low
//  OCC_ONE   | head holds the beat presented to WB
//  OCC_FULL  | head presented, skid holds the next beat, in_ready low
module mem_wb_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] aluresult_i,
    input  logic [DATA_W-1:0] readdata_i,
    input  logic [REG_AW-1:0] writereg_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] aluresult_o,
    output logic [DATA_W-1:0] readdata_o,
    output logic [REG_AW-1:0] writereg_o,
    output logic              regwrite_o,
    output logic [DATA_W-1:0] wb_data_o
);

    typedef struct packed {
        logic [DATA_W-1:0] aluresult;
        logic [DATA_W-1:0] readdata;
        logic [REG_AW-1:0] writereg;
        wb_ctrl_t          ctrl;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    occ_e     occ_q;
    occ_e     occ_d;
    payload_t in_pay;
    payload_t head_d;
    payload_t head_q;
    payload_t skid_q;
    logic     load_head;
    logic     load_skid;
    logic     accept;
    logic     deliver;

    assign in_pay  = {aluresult_i, readdata_i, writereg_i, regwrite_i, memtoreg_i};
    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Flush only drops the valids; stale payload stays in the registers unused.
    always_comb begin
        occ_d     = occ_q;
        load_head = 1'b0;
        load_skid = 1'b0;
        head_d    = in_pay;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d     = OCC_ONE;
                        load_head = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && deliver) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        occ_d     = OCC_FULL;
                        load_skid = 1'b1;
                    end else if (deliver) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (deliver) begin
                        occ_d     = OCC_ONE;
                        load_head = 1'b1;
                        head_d    = skid_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    // Outputs depend on registered state only, so in_ready has no path from out_ready.
    always_comb begin
        out_valid   = (occ_q != OCC_EMPTY);
        in_ready    = (occ_q != OCC_FULL);
        aluresult_o = head_q.aluresult;
        readdata_o  = head_q.readdata;
        writereg_o  = head_q.writereg;
        regwrite_o  = 1'b0;
        wb_data_o   = '0;
        if (occ_q != OCC_EMPTY) begin
            regwrite_o = head_q.ctrl.regwrite &
                         !(ZERO_REG && (head_q.writereg == REG_AW'(REG_ZERO)));
            wb_data_o  = head_q.ctrl.memtoreg ? head_q.readdata : head_q.aluresult;
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (load_head),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid),
        .d     (in_pay),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg with a 2-deep queue reference model.
module tb_mem_wb_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluresult_i;
    logic [31:0] readdata_i;
    logic [4:0]  writereg_i;
    logic        regwrite_i;
    logic        memtoreg_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluresult_o;
    logic [31:0] readdata_o;
    logic [4:0]  writereg_o;
    logic        regwrite_o;
    logic [31:0] wb_data_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] dlog[$];
    bit          m_acc;
    bit          m_dlv;
    beat_t       e;

    mem_wb_stage_reg dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluresult_i (aluresult_i),
        .readdata_i  (readdata_i),
        .writereg_i  (writereg_i),
        .regwrite_i  (regwrite_i),
        .memtoreg_i  (memtoreg_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluresult_o (aluresult_o),
        .readdata_o  (readdata_o),
        .writereg_o  (writereg_o),
        .regwrite_o  (regwrite_o),
        .wb_data_o   (wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of capacity two; flush and reset empty it.
    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            mq.delete();
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_dlv = (mq.size() > 0) && out_ready;
            if (m_dlv) begin
                dlog.push_back(mq[0].alu);
                void'(mq.pop_front());
            end
            if (m_acc)
                mq.push_back({aluresult_i, readdata_i, writereg_i, regwrite_i, memtoreg_i});
        end
    end

    always @(negedge clk) begin
        if (mq.size() > 0) begin
            e = mq[0];
            chk("m_out_valid", out_valid, 1);
            chk("m_aluresult", aluresult_o, e.alu);
            chk("m_readdata", readdata_o, e.rd);
            chk("m_writereg", writereg_o, e.wr);
            chk("m_wb_data", wb_data_o, e.mtr ? e.rd : e.alu);
            chk("m_regwrite", regwrite_o, e.rw && (e.wr != 0));
        end else begin
            chk("m_out_valid", out_valid, 0);
            chk("m_wb_data", wb_data_o, 0);
            chk("m_regwrite", regwrite_o, 0);
        end
        chk("m_in_ready", in_ready, mq.size() < 2);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] alu, input logic [31:0] rd,
                          input logic [4:0] wr, input bit rw, input bit mtr);
        in_valid    = v;
        aluresult_i = alu;
        readdata_i  = rd;
        writereg_i  = wr;
        regwrite_i  = rw;
        memtoreg_i  = mtr;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_regwrite", regwrite_o, 0);
        chk("rst_aluresult", aluresult_o, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Streaming at full rate
        dlog.delete();
        out_ready = 1'b1;
        set_in(1, 32'h10, 32'h0, 5'd1, 1, 0);
        tick();
        chk("t2_latency_valid", out_valid, 1);
        chk("t2_latency_alu", aluresult_o, 32'h10);
        set_in(1, 32'h20, 32'h0, 5'd2, 1, 0);
        tick();
        set_in(1, 32'h30, 32'h0, 5'd3, 1, 0);
        tick();
        chk("t2_in_ready", in_ready, 1);
        set_in(1, 32'h40, 32'h0, 5'd4, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("t2_drained", out_valid, 0);
        chk("t2_count", dlog.size(), 4);
        if (dlog.size() == 4) begin
            chk("t2_beat0", dlog[0], 32'h10);
            chk("t2_beat1", dlog[1], 32'h20);
            chk("t2_beat2", dlog[2], 32'h30);
            chk("t2_beat3", dlog[3], 32'h40);
        end

        // Back-pressure into the skid entry
        dlog.delete();
        out_ready = 1'b0;
        set_in(1, 32'hA, 32'h0, 5'd7, 1, 0);
        tick();
        chk("t3_ready_after_a", in_ready, 1);
        set_in(1, 32'hB, 32'h0, 5'd7, 1, 0);
        tick();
        chk("t3_ready_after_b", in_ready, 0);
        set_in(1, 32'hC, 32'h0, 5'd7, 1, 0);
        tick();
        chk("t3_head_held", aluresult_o, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("t3_head_b", aluresult_o, 32'hB);
        tick();
        chk("t3_head_c", aluresult_o, 32'hC);
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("t3_count", dlog.size(), 3);
        if (dlog.size() == 3) begin
            chk("t3_order0", dlog[0], 32'hA);
            chk("t3_order1", dlog[1], 32'hB);
            chk("t3_order2", dlog[2], 32'hC);
        end

        // Writeback mux select
        out_ready = 1'b0;
        set_in(1, 32'h4, 32'hDEADBEEF, 5'd3, 1, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("t4_wb_load", wb_data_o, 32'hDEADBEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_in(1, 32'h4, 32'hDEADBEEF, 5'd3, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("t4_wb_alu", wb_data_o, 32'h4);
        out_ready = 1'b1;
        tick();

        // Register 0 write squash
        out_ready = 1'b0;
        set_in(1, 32'h55, 32'h0, 5'd0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("t5_r0_squash", regwrite_o, 0);
        chk("t5_r0_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_in(1, 32'h56, 32'h0, 5'd5, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("t5_r5_write", regwrite_o, 1);
        out_ready = 1'b1;
        tick();

        // Flush while full with a beat offered
        dlog.delete();
        out_ready = 1'b0;
        set_in(1, 32'h61, 32'h0, 5'd1, 1, 0);
        tick();
        set_in(1, 32'h62, 32'h0, 5'd1, 1, 0);
        tick();
        chk("t6_full", in_ready, 0);
        flush = 1'b1;
        set_in(1, 32'h63, 32'h0, 5'd1, 1, 0);
        tick();
        flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_nothing_out", dlog.size(), 0);

        // Asynchronous reset while full
        dlog.delete();
        out_ready = 1'b0;
        set_in(1, 32'h71, 32'h0, 5'd1, 1, 0);
        tick();
        set_in(1, 32'h72, 32'h0, 5'd1, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("t1_full", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_wb_data", wb_data_o, 0);
        chk("t1_regwrite", regwrite_o, 0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("t1_stays_empty", out_valid, 0);
        chk("t1_nothing_out", dlog.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
